// File: rtl/mux3_sel_arbiter.sv
// Round-robin, burst-bounded arbiter that drives the select of the 3:1 priority bit mux.
// Defining ARB_FIXED_PRIO_EN swaps round-robin for fixed priority A > B > C.
module mux3_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_c,
    output logic [1:0] sel,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       gnt_c,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
    localparam logic [1:0] SRC_A     = 2'd0;
    localparam logic [1:0] SRC_B     = 2'd1;
    localparam logic [1:0] SRC_C     = 2'd2;

    state_t     state_r;
    logic [1:0] holder_r;
    logic [1:0] last_r;
    logic [7:0] count_r;

    logic [2:0] req_s;
    logic [1:0] arb_base_s;
    logic       release_s;
    logic [2:0] win_s;
    logic       win_valid_s;
    logic [1:0] win_idx_s;

    // First requester in the order p0, p1, p2; returns {valid, index}.
    function automatic logic [2:0] first_req(input logic [2:0] req_vec, input logic [1:0] p0,
                                             input logic [1:0] p1, input logic [1:0] p2);
        logic [2:0] result;
        if (req_vec[p0]) begin
            result = {1'b1, p0};
        end else if (req_vec[p1]) begin
            result = {1'b1, p1};
        end else if (req_vec[p2]) begin
            result = {1'b1, p2};
        end else begin
            result = 3'b000;
        end
        return result;
    endfunction

    function automatic logic [1:0] sel_code(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            SRC_A:   code = 2'b10;
            SRC_B:   code = 2'b01;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    // Release detection and winner selection; the holder ranks last after its own release.
    always_comb begin
        req_s      = {req_c, req_b, req_a};
        release_s  = 1'b0;
        arb_base_s = last_r;
        win_s      = 3'b000;
        if (state_r == GRANT) begin
            release_s  = !req_s[holder_r] || (count_r == BURST_MAX);
            arb_base_s = holder_r;
        end else begin
            release_s  = 1'b0;
            arb_base_s = last_r;
        end
`ifdef ARB_FIXED_PRIO_EN
        win_s = first_req(req_s, SRC_A, SRC_B, SRC_C);
`else
        case (arb_base_s)
            SRC_A:   win_s = first_req(req_s, SRC_B, SRC_C, SRC_A);
            SRC_B:   win_s = first_req(req_s, SRC_C, SRC_A, SRC_B);
            default: win_s = first_req(req_s, SRC_A, SRC_B, SRC_C);
        endcase
`endif
        win_valid_s = win_s[2];
        win_idx_s   = win_s[1:0];
    end

    // Grant FSM with registered select, strobes and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            holder_r <= SRC_C;
            last_r   <= SRC_C;
            count_r  <= 8'd0;
            sel      <= 2'b00;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            gnt_c    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, GRANT: begin
                    if (state_r == GRANT && !release_s) begin
                        count_r <= count_r + 8'd1;
                    end else begin
                        if (state_r == GRANT) begin
                            last_r <= holder_r;
                        end
                        if (win_valid_s) begin
                            state_r  <= GRANT;
                            holder_r <= win_idx_s;
                            count_r  <= 8'd1;
                            sel      <= sel_code(win_idx_s);
                            gnt_a    <= (win_idx_s == SRC_A);
                            gnt_b    <= (win_idx_s == SRC_B);
                            gnt_c    <= (win_idx_s == SRC_C);
                            busy     <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            count_r <= 8'd0;
                            sel     <= 2'b00;
                            gnt_a   <= 1'b0;
                            gnt_b   <= 1'b0;
                            gnt_c   <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= 8'd0;
                    sel     <= 2'b00;
                    gnt_a   <= 1'b0;
                    gnt_b   <= 1'b0;
                    gnt_c   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
